audio_sample_tick_gen: RTL

Programmable sample-rate tick generator that sits directly downstream of the audio speed controller. It consumes the 32-bit divider terminal count `clk_div_end` and produces a one-cycle `sample_tick` strobe and a square-wave `audio_clk` for the audio sample fetch/playback path. New divisor values are taken up only at period boundaries, so a speed change never produces a truncated or stretched period.

---
 rtl/audio_sample_tick_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/audio_sample_tick_gen.sv
// audio_sample_tick_gen
// Sample-rate tick generator fed by the audio speed controller's divider
// terminal count. Emits a one-cycle sample_tick every active_div+1 cycles and
// a square-wave audio_clk that toggles on each tick. A new divisor is taken
// up only at a period boundary (terminal count, restart or enable), so a
// speed change never truncates or stretches a running period.
//
// Optional feature macro: RANGE_CLAMP_EN
//   defined   -> the requested divisor is clamped to [MIN_DIV, MAX_DIV]
//   undefined -> the requested divisor is used as-is (D = 0 ticks every cycle)
module audio_sample_tick_gen #(
  parameter logic [31:0] DEFAULT_DIV = 32'd1227,
  parameter logic [31:0] MIN_DIV     = 32'd64,
  parameter logic [31:0] MAX_DIV     = 32'd65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        restart,
  input  logic [31:0] clk_div_end,
  output logic        sample_tick,
  output logic        audio_clk,
  output logic [31:0] active_div,
  output logic        div_changed
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] active_div_q;
  logic        tick_q;
  logic        aclk_q;
  logic        chg_q;

  // Divisor that a load would install this cycle.
  logic [31:0] div_d;
  // Whether that load would alter the divisor in use.
  logic        div_differs_s;

`ifdef RANGE_CLAMP_EN
  // Clamp the requested divisor into the supported range.
  function automatic logic [31:0] eff_div(input logic [31:0] x);
    logic [31:0] r;
    if (x < MIN_DIV) begin
      r = MIN_DIV;
    end else if (x > MAX_DIV) begin
      r = MAX_DIV;
    end else begin
      r = x;
    end
    return r;
  endfunction
`else
  // Pass the requested divisor straight through; no range bounds apply.
  function automatic logic [31:0] eff_div(input logic [31:0] x);
    return x;
  endfunction

  // The bounds are part of the parameter set but have no role here.
  logic [63:0] unused_bounds_s;
  assign unused_bounds_s = {MIN_DIV, MAX_DIV};
`endif

  assign div_d         = eff_div(clk_div_end);
  assign div_differs_s = (div_d != active_div_q);

  // Period FSM: counter, divisor loads, tick strobe and audio clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 32'd0;
      active_div_q <= DEFAULT_DIV;
      tick_q       <= 1'b0;
      aclk_q       <= 1'b0;
      chg_q        <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      tick_q <= 1'b0;
      chg_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q  <= 32'd0;
          aclk_q <= 1'b0;
          if (enable) begin
            // Start a fresh period with the currently requested divisor.
            state_q      <= ST_RUN;
            active_div_q <= div_d;
            chg_q        <= div_differs_s;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            // Leaving RUN suppresses any coincident terminal-count tick.
            state_q <= ST_IDLE;
            cnt_q   <= 32'd0;
            aclk_q  <= 1'b0;
          end else if (restart) begin
            // Restart wins over terminal count: realign, no tick.
            cnt_q        <= 32'd0;
            aclk_q       <= 1'b0;
            active_div_q <= div_d;
            chg_q        <= div_differs_s;
          end else if (cnt_q == active_div_q) begin
            // Period boundary: tick, toggle and take up the new divisor.
            cnt_q        <= 32'd0;
            tick_q       <= 1'b1;
            aclk_q       <= ~aclk_q;
            active_div_q <= div_d;
            chg_q        <= div_differs_s;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 32'd0;
          aclk_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_tick = tick_q;
  assign audio_clk   = aclk_q;
  assign active_div  = active_div_q;
  assign div_changed = chg_q;

endmodule
